// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg: shared window geometry and byte-index map for the conv pipeline
// KERNEL_DIM x KERNEL_DIM windows of PIX_W-bit pixels, packed byte k = row*KERNEL_DIM+col
package conv_window_gen_pkg;
  localparam int KERNEL_DIM = 5;
  localparam int PIX_W = 8;
  localparam int WIN_W = KERNEL_DIM * KERNEL_DIM * PIX_W;
  typedef logic [PIX_W-1:0] pix_t;
  function automatic int win_byte(input int row, input int col);
    return row * KERNEL_DIM + col;
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one image line of pixels, combinational read-before-write at a single address
// i_clk clock, i_we write enable, i_addr column, i_wdata write pixel, o_rdata pixel stored at i_addr
module conv_line_buffer #(
  parameter int DEPTH = 512,
  parameter int PIX_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [PIX_W-1:0]         i_wdata,
  output logic [PIX_W-1:0]         o_rdata
);
  logic [PIX_W-1:0] r_mem [DEPTH];
  assign o_rdata = r_mem[i_addr];
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to packed 5x5 sliding windows, no padding
// i_clk/i_rst (sync, active-high), i_sof clears position, i_pixel_data/_valid input stream,
// o_pixel_data packed window, o_pixel_data_valid window qualifier, o_frame_done last-pixel pulse
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sof,
  input  logic [PIX_W-1:0] i_pixel_data,
  input  logic             i_pixel_data_valid,
  output logic [WIN_W-1:0] o_pixel_data,
  output logic             o_pixel_data_valid,
  output logic             o_frame_done
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int NLB = KERNEL_DIM - 1;
  logic [CW-1:0] r_col, w_col, w_col_nxt;
  logic [RW-1:0] r_row, w_row, w_row_nxt;
  logic          w_last_col, w_last_row, w_win_ok;
  pix_t          w_lb  [NLB];
  pix_t          w_new [KERNEL_DIM];
  pix_t          r_win [KERNEL_DIM][KERNEL_DIM];
  // i_sof restarts the position in the same cycle so a coincident pixel lands at (0,0)
  assign w_col      = i_sof ? '0 : r_col;
  assign w_row      = i_sof ? '0 : r_row;
  assign w_last_col = w_col == CW'(IMG_WIDTH - 1);
  assign w_last_row = w_row == RW'(IMG_HEIGHT - 1);
  assign w_win_ok   = w_row >= RW'(NLB) && w_col >= CW'(NLB);
  assign w_col_nxt  = i_pixel_data_valid ? (w_last_col ? '0 : w_col + CW'(1)) : w_col;
  assign w_row_nxt  = (i_pixel_data_valid && w_last_col) ? (w_last_row ? '0 : w_row + RW'(1)) : w_row;
  // new rightmost column, oldest line at the top; each buffer takes the line below it
  always_comb begin
    for (int r = 0; r < NLB; r++) w_new[r] = w_lb[r];
    w_new[NLB] = i_pixel_data;
  end
  for (genvar i = 0; i < NLB; i++) begin : g_lb
    conv_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb (
      .i_clk   (i_clk),
      .i_we    (i_pixel_data_valid),
      .i_addr  (w_col),
      .i_wdata (w_new[i+1]),
      .o_rdata (w_lb[i])
    );
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col              <= '0;
      r_row              <= '0;
      r_win              <= '{default: '0};
      o_pixel_data_valid <= 1'b0;
      o_frame_done       <= 1'b0;
    end else begin
      r_col              <= w_col_nxt;
      r_row              <= w_row_nxt;
      o_pixel_data_valid <= i_pixel_data_valid && w_win_ok;
      o_frame_done       <= i_pixel_data_valid && w_last_col && w_last_row;
      if (i_pixel_data_valid)
        for (int r = 0; r < KERNEL_DIM; r++) begin
          for (int c = 0; c < KERNEL_DIM - 1; c++) r_win[r][c] <= r_win[r][c+1];
          r_win[r][KERNEL_DIM-1] <= w_new[r];
        end
    end
  end
  always_comb begin
    o_pixel_data = '0;
    for (int r = 0; r < KERNEL_DIM; r++)
      for (int c = 0; c < KERNEL_DIM; c++)
        o_pixel_data[win_byte(r, c)*PIX_W +: PIX_W] = r_win[r][c];
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: randomized-gap and random-image checks of conv_window_gen against a frame model
module tb_conv_window_gen;
  localparam int W = 8;
  localparam int H = 6;
  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_sof = 1'b0;
  logic [7:0]   i_pixel_data = '0;
  logic         i_pixel_data_valid = 1'b0;
  logic [199:0] o_pixel_data;
  logic         o_pixel_data_valid;
  logic         o_frame_done;
  int           n_tests = 0;
  int           n_fail = 0;
  logic [7:0]   img [H][W];
  always #5 i_clk = ~i_clk;
  conv_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_sof              (i_sof),
    .i_pixel_data       (i_pixel_data),
    .i_pixel_data_valid (i_pixel_data_valid),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_frame_done       (o_frame_done)
  );
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  function automatic logic [199:0] exp_win(input int r, input int c);
    logic [199:0] w = '0;
    for (int rr = 0; rr < 5; rr++)
      for (int cc = 0; cc < 5; cc++)
        w[(rr*5+cc)*8 +: 8] = img[r-4+rr][c-4+cc];
    return w;
  endfunction
  task automatic fill(input bit rnd, input logic [7:0] off);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = rnd ? 8'($urandom) : 8'(r*16 + c) + off;
  endtask
  task automatic run_frame(input int npix, input bit sof_first, input bit gaps,
                           output int nwin, output logic [199:0] first_w, output logic [199:0] last_w);
    int p;
    bit exp_v, exp_d;
    logic [199:0] held;
    p = 0;
    nwin = 0;
    first_w = '0;
    last_w = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (p < npix) begin
          if (gaps && $urandom_range(0, 1) == 1) begin
            held = o_pixel_data;
            for (int g = $urandom_range(1, 3); g > 0; g--) begin
              i_pixel_data_valid = 1'b0;
              i_sof = 1'b0;
              i_pixel_data = 8'($urandom);
              tick();
              n_tests++;
              if (o_pixel_data_valid !== 1'b0 || o_frame_done !== 1'b0 || o_pixel_data !== held) begin
                n_fail++;
                $display("FAIL gap hold: valid=%b done=%b data=%h required valid=0 done=0 data=%h",
                         o_pixel_data_valid, o_frame_done, o_pixel_data, held);
              end
            end
          end
          i_pixel_data_valid = 1'b1;
          i_sof = sof_first && p == 0;
          i_pixel_data = img[r][c];
          tick();
          exp_v = r >= 4 && c >= 4;
          exp_d = r == H-1 && c == W-1;
          n_tests++;
          if (o_pixel_data_valid !== exp_v || o_frame_done !== exp_d) begin
            n_fail++;
            $display("FAIL flags at (%0d,%0d): valid=%b done=%b required valid=%b done=%b",
                     r, c, o_pixel_data_valid, o_frame_done, exp_v, exp_d);
          end
          if (exp_v) begin
            n_tests++;
            if (o_pixel_data !== exp_win(r, c)) begin
              n_fail++;
              $display("FAIL window at (%0d,%0d): got %h required %h", r, c, o_pixel_data, exp_win(r, c));
            end
            nwin++;
            if (nwin == 1) first_w = o_pixel_data;
            last_w = o_pixel_data;
          end
          p++;
        end
    i_pixel_data_valid = 1'b0;
    i_sof = 1'b0;
  endtask
  task automatic check_first(input string name, input int nwin, input logic [199:0] fw);
    n_tests++;
    if (nwin !== 8 || fw[7:0] !== 8'h00 || fw[39:32] !== 8'h04 || fw[167:160] !== 8'h40 || fw[199:192] !== 8'h44) begin
      n_fail++;
      $display("FAIL %s: windows=%0d b0=%h b4=%h b20=%h b24=%h required 8 00 04 40 44",
               name, nwin, fw[7:0], fw[39:32], fw[167:160], fw[199:192]);
    end
  endtask
  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (o_pixel_data !== '0 || o_pixel_data_valid !== 1'b0 || o_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: data=%h valid=%b done=%b required all 0", o_pixel_data, o_pixel_data_valid, o_frame_done);
    end
    i_rst = 1'b0;
  endtask
  task automatic test_full_frame();
    int nwin;
    logic [199:0] fw, lw;
    fill(1'b0, 8'h00);
    run_frame(W*H, 1'b0, 1'b0, nwin, fw, lw);
    check_first("full frame first window", nwin, fw);
    n_tests++;
    if (lw[7:0] !== 8'h13 || lw[199:192] !== 8'h57) begin
      n_fail++;
      $display("FAIL last window: b0=%h b24=%h required 13 57", lw[7:0], lw[199:192]);
    end
    tick();
    n_tests++;
    if (o_frame_done !== 1'b0 || o_pixel_data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done one-shot: done=%b valid=%b required 0 0", o_frame_done, o_pixel_data_valid);
    end
  endtask
  task automatic test_gaps();
    int nwin;
    logic [199:0] fw, lw;
    fill(1'b0, 8'h00);
    run_frame(W*H, 1'b0, 1'b1, nwin, fw, lw);
    check_first("gapped frame", nwin, fw);
  endtask
  task automatic test_back_to_back();
    int nwin;
    logic [199:0] fw, lw;
    fill(1'b0, 8'h00);
    run_frame(W*H, 1'b0, 1'b0, nwin, fw, lw);
    fill(1'b0, 8'h80);
    run_frame(W*H, 1'b0, 1'b0, nwin, fw, lw);
    n_tests++;
    if (nwin !== 8 || fw[7:0] !== 8'h80) begin
      n_fail++;
      $display("FAIL back to back: windows=%0d b0=%h required 8 80", nwin, fw[7:0]);
    end
  endtask
  task automatic test_random_image();
    int nwin;
    logic [199:0] fw, lw;
    for (int f = 0; f < 2; f++) begin
      fill(1'b1, 8'h00);
      run_frame(W*H, 1'b0, f == 1, nwin, fw, lw);
      n_tests++;
      if (nwin !== 8) begin
        n_fail++;
        $display("FAIL random image count: windows=%0d required 8", nwin);
      end
    end
  endtask
  task automatic test_reset_mid();
    int nwin;
    logic [199:0] fw, lw;
    fill(1'b0, 8'h00);
    run_frame(3*W + 2, 1'b0, 1'b0, nwin, fw, lw);
    i_rst = 1'b1;
    i_pixel_data_valid = 1'b1;
    i_pixel_data = img[3][2];
    tick();
    n_tests++;
    if (o_pixel_data !== '0 || o_pixel_data_valid !== 1'b0 || o_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid-frame reset: data=%h valid=%b done=%b required all 0", o_pixel_data, o_pixel_data_valid, o_frame_done);
    end
    i_rst = 1'b0;
    i_pixel_data_valid = 1'b0;
    run_frame(W*H, 1'b0, 1'b0, nwin, fw, lw);
    check_first("after mid-frame reset", nwin, fw);
  endtask
  task automatic test_sof_abort();
    int nwin;
    logic [199:0] fw, lw;
    fill(1'b0, 8'h00);
    run_frame(4*W + 6, 1'b0, 1'b0, nwin, fw, lw);
    n_tests++;
    if (nwin !== 2) begin
      n_fail++;
      $display("FAIL partial frame windows: got %0d required 2", nwin);
    end
    run_frame(W*H, 1'b1, 1'b0, nwin, fw, lw);
    check_first("after sof abort", nwin, fw);
  endtask
  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_back_to_back();
    test_random_image();
    test_reset_mid();
    test_sof_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
